// File: rtl/neo_pal_card_busctl.sv
`default_nettype none
// ============================================================================
// neo_pal_card_busctl - 68k palette/memory-card bus buffer sequencer (G0/G1/DIR, nDTACK)
// Optional feature macro: MEMCARD_EN (sequenced card accesses).   Rev 1.0
// ============================================================================
module neo_pal_card_busctl #(
  parameter int PAL_WAIT  = 2,
  parameter int CARD_WAIT = 4
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic nPAL_SEL,
  input  logic nCARD_SEL,
  input  logic M68K_RW,
  input  logic VID_BUSY,
  output logic G0,
  output logic G1,
  output logic DIR,
  output logic PAL_ADDR_SEL,
  output logic nDTACK,
  output logic BUSY
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ACCESS  = 3'd2,
    S_ACK     = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  localparam logic [3:0] PAL_CNT  = 4'(PAL_WAIT);
  localparam logic [3:0] CARD_CNT = 4'(CARD_WAIT);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       tgt_pal_q, tgt_pal_d;
  logic       block_q, block_d;
  logic       g0_q, g0_d;
  logic       g1_q, g1_d;
  logic       dir_q, dir_d;
  logic       pas_q, pas_d;
  logic       ndtack_q, ndtack_d;
  logic       busy_q, busy_d;
  logic       act_rel;

  // Select of the target currently being served has been released.
  assign act_rel = tgt_pal_q ? nPAL_SEL : nCARD_SEL;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_pal_d = tgt_pal_q;
    g0_d      = g0_q;
    g1_d      = g1_q;
    dir_d     = dir_q;
    pas_d     = pas_q;
    ndtack_d  = ndtack_q;

    // A simultaneous palette+card select locks the card out until it is released.
    block_d = block_q;
    if (!nPAL_SEL && !nCARD_SEL) begin
      block_d = 1'b1;
    end else if (nCARD_SEL) begin
      block_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!nPAL_SEL) begin
          if (!VID_BUSY) begin
            state_d   = S_SETUP;
            tgt_pal_d = 1'b1;
            dir_d     = M68K_RW;
            pas_d     = 1'b1;
          end
        end else if (!nCARD_SEL && !block_q) begin
          tgt_pal_d = 1'b0;
`ifdef MEMCARD_EN
          state_d   = S_SETUP;
          dir_d     = M68K_RW;
`else
          // No card fitted: acknowledge straight away as an open-bus cycle.
          state_d   = S_ACK;
          ndtack_d  = 1'b0;
`endif
        end
      end

      S_SETUP: begin
        cnt_d = tgt_pal_q ? PAL_CNT : CARD_CNT;
        if (act_rel) begin
          state_d = S_RECOVER;
          pas_d   = 1'b0;
        end else if (tgt_pal_q && VID_BUSY) begin
          state_d = S_IDLE;
          pas_d   = 1'b0;
        end else begin
          state_d = S_ACCESS;
          g0_d    = tgt_pal_q;
          g1_d    = !tgt_pal_q;
        end
      end

      S_ACCESS: begin
        if (act_rel) begin
          state_d = S_RECOVER;
          g0_d    = 1'b1;
          g1_d    = 1'b1;
          pas_d   = 1'b0;
        end else if (tgt_pal_q && VID_BUSY) begin
          state_d = S_IDLE;
          g0_d    = 1'b1;
          g1_d    = 1'b1;
          pas_d   = 1'b0;
        end else if (cnt_q == 4'd1) begin
          state_d  = S_ACK;
          ndtack_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      // Video contention during ACK is ignored so read data stays valid.
      S_ACK: begin
        if (act_rel) begin
          state_d  = S_RECOVER;
          g0_d     = 1'b1;
          g1_d     = 1'b1;
          pas_d    = 1'b0;
          ndtack_d = 1'b1;
        end
      end

      S_RECOVER: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        g0_d     = 1'b1;
        g1_d     = 1'b1;
        pas_d    = 1'b0;
        ndtack_d = 1'b1;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      tgt_pal_q <= 1'b0;
      block_q   <= 1'b0;
      g0_q      <= 1'b1;
      g1_q      <= 1'b1;
      dir_q     <= 1'b1;
      pas_q     <= 1'b0;
      ndtack_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_pal_q <= tgt_pal_d;
      block_q   <= block_d;
      g0_q      <= g0_d;
      g1_q      <= g1_d;
      dir_q     <= dir_d;
      pas_q     <= pas_d;
      ndtack_q  <= ndtack_d;
      busy_q    <= busy_d;
    end
  end

  assign G0           = g0_q;
  assign G1           = g1_q;
  assign DIR          = dir_q;
  assign PAL_ADDR_SEL = pas_q;
  assign nDTACK       = ndtack_q;
  assign BUSY         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_neo_pal_card_busctl.sv
`default_nettype none
// Bench for neo_pal_card_busctl: directed timing cases plus random CPU/video traffic
// compared cycle by cycle against a timeline-based reference model.
module tb_neo_pal_card_busctl;

  localparam int PAL_WAIT  = 2;
  localparam int CARD_WAIT = 4;

  logic clk    = 1'b0;
  logic nreset = 1'b0;
  logic npal   = 1'b1;
  logic ncard  = 1'b1;
  logic rw     = 1'b1;
  logic vid    = 1'b0;
  logic g0, g1, dir, pas, ndtack, busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: phase 0 idle, 1 request in flight (age 0 = setup,
  // 1..WAIT = access cycles), 2 acknowledged, 3 recovery.
  int   m_phase;
  int   m_age;
  bit   m_pal;
  bit   m_block;
  logic e_g0, e_g1, e_dir, e_pas, e_nd;

  always #5 clk = ~clk;

  neo_pal_card_busctl #(
    .PAL_WAIT (PAL_WAIT),
    .CARD_WAIT(CARD_WAIT)
  ) dut (
    .CLK         (clk),
    .nRESET      (nreset),
    .nPAL_SEL    (npal),
    .nCARD_SEL   (ncard),
    .M68K_RW     (rw),
    .VID_BUSY    (vid),
    .G0          (g0),
    .G1          (g1),
    .DIR         (dir),
    .PAL_ADDR_SEL(pas),
    .nDTACK      (ndtack),
    .BUSY        (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_age   = 0;
    m_pal   = 1'b0;
    m_block = 1'b0;
    e_g0    = 1'b1;
    e_g1    = 1'b1;
    e_dir   = 1'b1;
    e_pas   = 1'b0;
    e_nd    = 1'b1;
  endtask

  task automatic model_recover();
    m_phase = 3;
    e_g0    = 1'b1;
    e_g1    = 1'b1;
    e_pas   = 1'b0;
    e_nd    = 1'b1;
  endtask

  task automatic model_step();
    bit blk_next;
    bit rel;
    int wait_n;
    blk_next = m_block;
    if (!npal && !ncard) blk_next = 1'b1;
    else if (ncard)      blk_next = 1'b0;
    rel    = m_pal ? npal : ncard;
    wait_n = m_pal ? PAL_WAIT : CARD_WAIT;
    case (m_phase)
      0: begin
        if (!npal) begin
          if (!vid) begin
            m_pal = 1'b1; m_phase = 1; m_age = 0; e_dir = rw; e_pas = 1'b1;
          end
        end else if (!ncard && !m_block) begin
          m_pal = 1'b0;
`ifdef MEMCARD_EN
          m_phase = 1; m_age = 0; e_dir = rw;
`else
          m_phase = 2; e_nd = 1'b0;
`endif
        end
      end
      1: begin
        if (rel) model_recover();
        else if (m_pal && vid) begin
          m_phase = 0; e_g0 = 1'b1; e_g1 = 1'b1; e_pas = 1'b0;
        end else if (m_age == wait_n) begin
          m_phase = 2; e_nd = 1'b0;
        end else begin
          m_age++; e_g0 = m_pal; e_g1 = !m_pal;
        end
      end
      2: if (rel) model_recover();
      default: m_phase = 0;
    endcase
    m_block = blk_next;
  endtask

  task automatic cyc(input logic p, input logic c, input logic r, input logic v);
    npal = p; ncard = c; rw = r; vid = v;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    check_eq("outs", 32'({g0, g1, dir, pas, ndtack, busy}),
             32'({e_g0, e_g1, e_dir, e_pas, e_nd, (m_phase != 0)}));
  endtask

  // Edges counted from the sampling edge until nDTACK is seen low.
  task automatic measure(input string tag, input logic p, input logic c, input logic r,
                         input int exp_n);
    int n;
    n = 0;
    do begin
      cyc(p, c, r, 1'b0);
      n++;
    end while (ndtack && n < 40);
    check_eq(tag, 32'(n), 32'(exp_n));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   kind, hold, gap;
    logic p, c, r, v;

    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_eq("rst_outs", 32'({g0, g1, dir, pas, ndtack, busy}), 32'(6'b111010));
    nreset = 1'b1;
    repeat (3) cyc(1, 1, 1, 0);

    // Palette read, no video contention
    measure("pal_rd_lat", 0, 1, 1, PAL_WAIT + 2);
    cyc(0, 1, 1, 0);
    check_eq("pal_rd_g1", 32'(g1), 32'(0));
    cyc(1, 1, 1, 0);
    check_eq("pal_rd_rel", 32'(ndtack), 32'(1));
    cyc(1, 1, 1, 0);
    check_eq("pal_rd_idle", 32'(busy), 32'(0));

    // Palette write aborted by video in its first access cycle, then retried
    cyc(0, 1, 0, 0);
    check_eq("pal_wr_dir", 32'(dir), 32'(0));
    cyc(0, 1, 0, 0);
    check_eq("pal_wr_g1", 32'(g1), 32'(0));
    cyc(0, 1, 0, 1);
    check_eq("abort_g1", 32'(g1), 32'(1));
    check_eq("abort_pas", 32'(pas), 32'(0));
    cyc(0, 1, 0, 1);
    check_eq("abort_wait", 32'(busy), 32'(0));
    measure("pal_retry_lat", 0, 1, 0, PAL_WAIT + 2);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);

    // Card write
`ifdef MEMCARD_EN
    measure("card_lat", 1, 0, 0, CARD_WAIT + 2);
    check_eq("card_g0", 32'(g0), 32'(0));
`else
    measure("card_lat", 1, 0, 0, 1);
    check_eq("card_g0", 32'(g0), 32'(1));
`endif
    check_eq("card_g1", 32'(g1), 32'(1));
    cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 0);

    // Both selects together: palette wins, card stays locked out
    measure("both_lat", 0, 0, 1, PAL_WAIT + 2);
    check_eq("both_g0", 32'(g0), 32'(1));
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    check_eq("both_card_ignored", 32'(busy), 32'(0));
    cyc(1, 1, 1, 0);

    // CPU cycle killed during access
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(1, 1, 1, 0);
    check_eq("kill_ndtack", 32'(ndtack), 32'(1));
    check_eq("kill_g1", 32'(g1), 32'(1));
    cyc(1, 1, 1, 0);

    // Asynchronous reset in the middle of a palette write access
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    npal   = 1'b1;
    nreset = 1'b0;
    #1;
    check_eq("rst_mid", 32'({g0, g1, dir, pas, ndtack, busy}), 32'(6'b111010));
    model_reset();
    @(posedge clk); #1;
    nreset = 1'b1;
    #1;
    check_eq("rst_rel", 32'({g0, g1, dir, pas, ndtack, busy}), 32'(6'b111010));
    cyc(1, 1, 1, 0);

    // Random CPU traffic with bursty video contention and RW wobble
    for (int t = 0; t < 250; t++) begin
      kind = $urandom_range(0, 5);
      hold = $urandom_range(1, 12);
      gap  = $urandom_range(1, 3);
      p    = (kind <= 2 || kind == 5) ? 1'b0 : 1'b1;
      c    = (kind >= 3) ? 1'b0 : 1'b1;
      r    = 1'($urandom_range(0, 1));
      for (int h = 0; h < hold; h++) begin
        v = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 7) == 0) r = ~r;
        if (kind == 5 && h == hold / 2 && $urandom_range(0, 1) == 1) p = 1'b1;
        cyc(p, c, r, v);
      end
      for (int g = 0; g < gap; g++) begin
        cyc(1, 1, r, 1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
